// File: rtl/velocity_peak_serializer.sv
// rtl/velocity_peak_serializer.sv - Doppler peak-bin capture and signed velocity word serializer
// Optional stall abort: define VPS_STALL_TIMEOUT_EN.
module velocity_peak_serializer #(
  parameter int NUM_PEAKS = 8,
  parameter int NUM_BINS  = 16,
  parameter int VEL_SCALE = 12
`ifdef VPS_STALL_TIMEOUT_EN
  , parameter int STALL_TIMEOUT = 64
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*NUM_PEAKS-1:0] peak_bins_in,
  input  logic                   in_valid,
  output logic [15:0]            vel_data,
  output logic [7:0]             vel_bin,
  output logic                   vel_last,
  output logic                   vel_valid,
  input  logic                   vel_ready,
  output logic                   busy,
  output logic [15:0]            frame_count,
  output logic [7:0]             drop_count,
  output logic [7:0]             empty_count,
  output logic [7:0]             abort_count
);

  localparam int IW = (NUM_PEAKS > 1) ? $clog2(NUM_PEAKS) : 1;
  localparam logic signed [15:0] ZERO_BIN = 16'(NUM_BINS / 2);
  localparam logic signed [15:0] SCALE    = 16'(VEL_SCALE);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state;
  logic [8*NUM_PEAKS-1:0] peak_buf;
  logic [NUM_PEAKS-1:0]   mask;
  logic [IW-1:0]          cur_idx;

  logic [NUM_PEAKS-1:0]   in_mask;
  logic [NUM_PEAKS-1:0]   rem_mask;
  logic [NUM_PEAKS-1:0]   src_mask;
  logic [8*NUM_PEAKS-1:0] src_vec;
  logic [IW-1:0]          load_idx;
  logic                   load_last;
  logic [7:0]             load_bin;
  logic                   handshake;
  logic                   stall_hit;

  function automatic logic [NUM_PEAKS-1:0] valid_mask(input logic [8*NUM_PEAKS-1:0] v);
    logic [NUM_PEAKS-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_PEAKS; k++)
      m[k] = (v[8*k +: 8] != 8'd0) && (int'(v[8*k +: 8]) < NUM_BINS);
    return m;
  endfunction

  function automatic logic [IW-1:0] lowest_idx(input logic [NUM_PEAKS-1:0] m);
    logic [IW-1:0] idx;
    idx = '0;
    for (int k = NUM_PEAKS - 1; k >= 0; k--)
      if (m[k]) idx = IW'(k);
    return idx;
  endfunction

  function automatic logic [IW-1:0] highest_idx(input logic [NUM_PEAKS-1:0] m);
    logic [IW-1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_PEAKS; k++)
      if (m[k]) idx = IW'(k);
    return idx;
  endfunction

  // Bin offset from the zero-velocity bin, scaled; fits 16 bits for any 8-bit scale.
  function automatic logic [15:0] to_vel(input logic [7:0] b);
    logic signed [15:0] d;
    d = $signed({8'd0, b}) - ZERO_BIN;
    return 16'(d * SCALE);
  endfunction

  // One load path serves both the first word (from the input) and follow-ups (from the buffer).
  always_comb begin
    in_mask   = valid_mask(peak_bins_in);
    rem_mask  = mask & ~(NUM_PEAKS'(1) << cur_idx);
    src_mask  = (state == IDLE) ? in_mask : rem_mask;
    src_vec   = (state == IDLE) ? peak_bins_in : peak_buf;
    load_idx  = lowest_idx(src_mask);
    load_last = (load_idx == highest_idx(src_mask));
    load_bin  = src_vec[int'(load_idx)*8 +: 8];
    handshake = vel_valid && vel_ready;
  end

`ifdef VPS_STALL_TIMEOUT_EN
  logic [15:0] stall_cnt;

  assign stall_hit = (state == SEND) && vel_valid && !vel_ready &&
                     (stall_cnt == 16'(STALL_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt   <= '0;
      abort_count <= '0;
    end else begin
      if ((state == SEND) && vel_valid && !vel_ready && !stall_hit)
        stall_cnt <= stall_cnt + 16'd1;
      else
        stall_cnt <= '0;
      if (stall_hit && (abort_count != 8'hFF))
        abort_count <= abort_count + 8'd1;
    end
  end
`else
  assign stall_hit   = 1'b0;
  assign abort_count = 8'd0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      peak_buf    <= '0;
      mask        <= '0;
      cur_idx     <= '0;
      vel_data    <= '0;
      vel_bin     <= '0;
      vel_last    <= 1'b0;
      vel_valid   <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
      empty_count <= '0;
    end else begin
      if (in_valid && (state == SEND) && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;

      case (state)
        IDLE: begin
          if (in_valid) begin
            peak_buf <= peak_bins_in;
            if (in_mask == '0) begin
              frame_count <= frame_count + 16'd1;
              if (empty_count != 8'hFF)
                empty_count <= empty_count + 8'd1;
            end else begin
              mask      <= in_mask;
              cur_idx   <= load_idx;
              vel_bin   <= load_bin;
              vel_data  <= to_vel(load_bin);
              vel_last  <= load_last;
              vel_valid <= 1'b1;
              busy      <= 1'b1;
              state     <= SEND;
            end
          end
        end

        SEND: begin
          if (stall_hit) begin
            mask      <= '0;
            vel_valid <= 1'b0;
            vel_last  <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (handshake) begin
            mask <= rem_mask;
            if (rem_mask != '0) begin
              cur_idx  <= load_idx;
              vel_bin  <= load_bin;
              vel_data <= to_vel(load_bin);
              vel_last <= load_last;
            end else begin
              vel_valid   <= 1'b0;
              vel_last    <= 1'b0;
              busy        <= 1'b0;
              state       <= IDLE;
              frame_count <= frame_count + 16'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_velocity_peak_serializer.sv
// tb/tb_velocity_peak_serializer.sv - directed self-checking bench for velocity_peak_serializer
module tb_velocity_peak_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] peak_bins_in;
  logic        in_valid;
  logic [15:0] vel_data;
  logic [7:0]  vel_bin;
  logic        vel_last;
  logic        vel_valid;
  logic        vel_ready;
  logic        busy;
  logic [15:0] frame_count;
  logic [7:0]  drop_count;
  logic [7:0]  empty_count;
  logic [7:0]  abort_count;

  int compared   = 0;
  int mismatched = 0;

  velocity_peak_serializer dut (
    .clk          (clk),
    .reset        (reset),
    .peak_bins_in (peak_bins_in),
    .in_valid     (in_valid),
    .vel_data     (vel_data),
    .vel_bin      (vel_bin),
    .vel_last     (vel_last),
    .vel_valid    (vel_valid),
    .vel_ready    (vel_ready),
    .busy         (busy),
    .frame_count  (frame_count),
    .drop_count   (drop_count),
    .empty_count  (empty_count),
    .abort_count  (abort_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the presented word: valid, bin, signed velocity, last flag.
  task automatic chk_word(input string tag, input logic [7:0] bin, input logic [15:0] vel,
                          input logic last);
    chk({tag, ".valid"}, {31'd0, vel_valid}, 32'd1);
    chk({tag, ".bin"},   {24'd0, vel_bin},   {24'd0, bin});
    chk({tag, ".data"},  {16'd0, vel_data},  {16'd0, vel});
    chk({tag, ".last"},  {31'd0, vel_last},  {31'd0, last});
  endtask

  initial begin
    reset        = 1'b1;
    peak_bins_in = '0;
    in_valid     = 1'b0;
    vel_ready    = 1'b1;
    repeat (3) step();
    chk("rst.valid", {31'd0, vel_valid}, 32'd0);
    chk("rst.busy",  {31'd0, busy},      32'd0);
    chk("rst.data",  {16'd0, vel_data},  32'd0);
    chk("rst.frame", {16'd0, frame_count}, 32'd0);
    chk("rst.drop",  {24'd0, drop_count},  32'd0);
    chk("rst.empty", {24'd0, empty_count}, 32'd0);
    chk("rst.abort", {24'd0, abort_count}, 32'd0);
    reset = 1'b0;
    step();

    // Two-word frame: slots 0 and 2
    peak_bins_in = 64'h0000_0000_0009_0003;
    in_valid     = 1'b1;
    step();
    in_valid = 1'b0;
    chk_word("t1.w0", 8'd3, 16'(-60), 1'b0);
    chk("t1.busy", {31'd0, busy}, 32'd1);
    step();
    chk_word("t1.w1", 8'd9, 16'd12, 1'b1);
    step();
    chk("t1.end.valid", {31'd0, vel_valid}, 32'd0);
    chk("t1.end.busy",  {31'd0, busy},      32'd0);
    chk("t1.frame", {16'd0, frame_count}, 32'd1);

    // Empty vector
    peak_bins_in = 64'h0;
    in_valid     = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t2.valid", {31'd0, vel_valid}, 32'd0);
    chk("t2.busy",  {31'd0, busy},      32'd0);
    chk("t2.empty", {24'd0, empty_count}, 32'd1);
    chk("t2.frame", {16'd0, frame_count}, 32'd2);

    // Out-of-range bin 20 is dropped from the mask
    peak_bins_in = 64'h0000_0000_0000_1405;
    in_valid     = 1'b1;
    step();
    in_valid = 1'b0;
    chk_word("t3.w0", 8'd5, 16'(-36), 1'b1);
    step();
    chk("t3.end.valid", {31'd0, vel_valid}, 32'd0);
    chk("t3.frame", {16'd0, frame_count}, 32'd3);
    chk("t3.empty", {24'd0, empty_count}, 32'd1);

    // Stall with a dropped vector, then drop on the final-handshake cycle
    vel_ready    = 1'b0;
    peak_bins_in = 64'h0000_0000_000E_0201;
    in_valid     = 1'b1;
    step();
    in_valid = 1'b0;
    chk_word("t4.w0", 8'd1, 16'(-84), 1'b0);
    step();
    step();
    peak_bins_in = 64'h0000_0000_0000_0007;
    in_valid     = 1'b1;
    step();
    in_valid = 1'b0;
    chk_word("t4.hold", 8'd1, 16'(-84), 1'b0);
    chk("t4.drop", {24'd0, drop_count}, 32'd1);
    step();
    chk_word("t4.hold2", 8'd1, 16'(-84), 1'b0);
    vel_ready = 1'b1;
    step();
    chk_word("t4.w1", 8'd2, 16'(-72), 1'b0);
    step();
    chk_word("t4.w2", 8'd14, 16'd72, 1'b1);
    peak_bins_in = 64'h0000_0000_0000_0004;
    in_valid     = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t4.end.valid", {31'd0, vel_valid}, 32'd0);
    chk("t4.end.busy",  {31'd0, busy},      32'd0);
    chk("t4.drop2", {24'd0, drop_count},  32'd2);
    chk("t4.frame", {16'd0, frame_count}, 32'd4);
    step();
    chk("t4.idle.valid", {31'd0, vel_valid}, 32'd0);

    // Async reset mid-frame
    vel_ready    = 1'b0;
    peak_bins_in = 64'h0000_0000_0009_0003;
    in_valid     = 1'b1;
    step();
    in_valid = 1'b0;
    chk_word("t5.w0", 8'd3, 16'(-60), 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("t5.rst.valid", {31'd0, vel_valid}, 32'd0);
    chk("t5.rst.busy",  {31'd0, busy},      32'd0);
    chk("t5.rst.frame", {16'd0, frame_count}, 32'd0);
    chk("t5.rst.drop",  {24'd0, drop_count},  32'd0);
    chk("t5.rst.empty", {24'd0, empty_count}, 32'd0);
    step();
    reset     = 1'b0;
    vel_ready = 1'b1;
    step();
    peak_bins_in = 64'h0000_0000_0000_0900;
    in_valid     = 1'b1;
    step();
    in_valid = 1'b0;
    chk_word("t5.w1", 8'd9, 16'd12, 1'b1);
    step();
    chk("t5.end.valid", {31'd0, vel_valid}, 32'd0);
    chk("t5.frame", {16'd0, frame_count}, 32'd1);
    chk("t5.abort", {24'd0, abort_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
